// File: rtl/instr_mem_loader_if.sv
// Bundles the loader's control, byte-stream and memory-write signals.
// The slave modport is the loader itself; the master modport is whatever
// sources the program bytes and consumes the memory writes / status.
interface instr_mem_loader_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] num_words;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  start, num_words, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
  );

  modport master (
    output start, num_words, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into words and
// writes them to consecutive word addresses starting at 0, holding the CPU
// while a load is in progress. Lengths of 0 or above DEPTH are rejected.
module instr_mem_loader #(
  parameter int DEPTH  = 100,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_mem_loader_if.slave     ld
);

  localparam int BYTES = WORD_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    byte_cnt_q;
  logic [ADDR_W-1:0]   word_idx_q;
  logic [ADDR_W-1:0]   num_q;
  // Holds the first BYTES-1 bytes of the word; the final byte is taken
  // straight from the input when the word is committed.
  logic [WORD_W-9:0]   asm_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                error_q;

  logic                byte_ready_c;
  logic                cpu_hold_c;
  logic                busy_c;
  logic                done_c;
  logic                len_bad;
  logic                last_word;
  logic                xfer;

  assign len_bad   = (ld.num_words == '0) || (ld.num_words > DEPTH_A);
  assign last_word = (word_idx_q == num_q - ADDR_W'(1));
  assign xfer      = (state_q == RECV) && ld.byte_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d      = state_q;
    byte_ready_c = 1'b0;
    cpu_hold_c   = 1'b0;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done_c = (state_q == DONE);
        if (ld.start) state_d = len_bad ? IDLE : RECV;
      end
      RECV: begin
        byte_ready_c = 1'b1;
        cpu_hold_c   = 1'b1;
        busy_c       = 1'b1;
        if (ld.byte_valid && (byte_cnt_q == LAST_BYTE)) state_d = WRITE;
      end
      WRITE: begin
        cpu_hold_c = 1'b1;
        busy_c     = 1'b1;
        state_d    = last_word ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: length latch, byte packing, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      num_q       <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (ld.start) begin
            if (len_bad) begin
              error_q <= 1'b1;
            end else begin
              error_q    <= 1'b0;
              num_q      <= ld.num_words;
              word_idx_q <= '0;
              byte_cnt_q <= '0;
            end
          end
        end
        RECV: begin
          if (xfer) begin
            if (byte_cnt_q == LAST_BYTE) begin
              // Commit the word: the write is visible during the WRITE cycle.
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_idx_q;
              mem_wdata_q <= {asm_q, ld.byte_in};
            end else begin
              asm_q      <= {asm_q[WORD_W-17:0], ld.byte_in};
              byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          if (!last_word) begin
            word_idx_q <= word_idx_q + ADDR_W'(1);
            byte_cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ld.byte_ready = byte_ready_c;
  assign ld.cpu_hold   = cpu_hold_c;
  assign ld.busy       = busy_c;
  assign ld.done       = done_c;
  assign ld.mem_we     = mem_we_q;
  assign ld.mem_addr   = mem_addr_q;
  assign ld.mem_wdata  = mem_wdata_q;
  assign ld.error      = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: expected writes are queued as words
// are sent and checked by a monitor whenever mem_we is seen.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.WORD_W(32), .ADDR_W(32)) ld ();

  instr_mem_loader #(.DEPTH(100), .WORD_W(32), .ADDR_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (ld)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [63:0] exp_q[$];
  logic prev_we = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock step; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] n);
    ld.start     = 1'b1;
    ld.num_words = n;
    tick();
    ld.start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_stall);
    int guard;
    repeat ($urandom_range(0, max_stall)) tick();
    ld.byte_valid = 1'b1;
    ld.byte_in    = b;
    guard = 0;
    while (!ld.byte_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!ld.byte_ready) chk("byte_ready_timeout", 64'(ld.byte_ready), 64'd1);
    tick();
    ld.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input int max_stall);
    exp_q.push_back({addr, w});
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], max_stall);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!ld.done && k < budget) begin
      tick();
      k++;
    end
    chk("done_reached", 64'(ld.done), 64'd1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("hold_released", 64'(ld.cpu_hold), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, 64'(ld.byte_ready), 64'd0);
    chk({tag, "_mem_we"},     64'(ld.mem_we),     64'd0);
    chk({tag, "_cpu_hold"},   64'(ld.cpu_hold),   64'd0);
    chk({tag, "_busy"},       64'(ld.busy),       64'd0);
    chk({tag, "_done"},       64'(ld.done),       64'd0);
    chk({tag, "_error"},      64'(ld.error),      64'd0);
    chk({tag, "_mem_addr"},   64'(ld.mem_addr),   64'd0);
    chk({tag, "_mem_wdata"},  64'(ld.mem_wdata),  64'd0);
  endtask

  // Write monitor: every mem_we must match the next queued write, last one
  // cycle, and coincide with byte_ready low.
  always @(negedge clk) begin
    logic [63:0] e;
    if (ld.mem_we) begin
      chk("we_single_cycle", 64'(prev_we), 64'd0);
      chk("ready_low_in_write", 64'(ld.byte_ready), 64'd0);
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(ld.mem_addr), 64'(e[63:32]));
        chk("wr_data", 64'(ld.mem_wdata), 64'(e[31:0]));
        $display("write addr=%0d data=%08h", ld.mem_addr, ld.mem_wdata);
      end
    end
    prev_we = ld.mem_we;
  end

  initial begin
    logic [31:0] w;
    logic [31:0] last_w;
    ld.start = 1'b0;
    ld.num_words = '0;
    ld.byte_in = '0;
    ld.byte_valid = 1'b0;
    last_w = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1-word load, back-to-back bytes
    do_start(32'd1);
    chk("busy_after_start", 64'(ld.busy), 64'd1);
    send_word(32'd0, 32'hA8000003, 0);
    chk("we_after_4th_byte", 64'(ld.mem_we), 64'd1);
    tick();
    chk("done_1word", 64'(ld.done), 64'd1);
    chk("hold_1word", 64'(ld.cpu_hold), 64'd0);
    chk("we_dropped", 64'(ld.mem_we), 64'd0);

    // 3-word load with random stalls
    do_start(32'd3);
    chk("done_cleared", 64'(ld.done), 64'd0);
    send_word(32'd0, 32'h04862000, 2);
    send_word(32'd1, 32'h84E70010, 2);
    send_word(32'd2, 32'h04E60010, 2);
    wait_done(20);

    // Length check: 0 and DEPTH+1 rejected
    do_start(32'd0);
    chk("err_len0", 64'(ld.error), 64'd1);
    chk("busy_len0", 64'(ld.busy), 64'd0);
    chk("done_len0", 64'(ld.done), 64'd0);
    tick();
    chk("err_sticky", 64'(ld.error), 64'd1);
    do_start(32'd101);
    chk("err_len101", 64'(ld.error), 64'd1);
    chk("busy_len101", 64'(ld.busy), 64'd0);

    // Full-depth load
    do_start(32'd100);
    chk("err_cleared", 64'(ld.error), 64'd0);
    chk("hold_loading", 64'(ld.cpu_hold), 64'd1);
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      last_w = w;
      send_word(32'(i), w, 0);
    end
    wait_done(20);
    chk("last_addr_99", 64'(ld.mem_addr), 64'd99);
    chk("last_data_held", 64'(ld.mem_wdata), 64'(last_w));

    // start during RECV is ignored
    do_start(32'd2);
    exp_q.push_back({32'd0, 32'h11223344});
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_start(32'd1);
    chk("busy_after_ignored_start", 64'(ld.busy), 64'd1);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_word(32'd1, 32'h55667788, 1);
    wait_done(20);

    // Asynchronous reset mid-word
    do_start(32'd2);
    send_word(32'd0, 32'hDEADBEEF, 0);
    send_byte(8'hCA, 0);
    send_byte(8'hFE, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    chk("no_pending_writes", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_start(32'd1);
    send_word(32'd0, 32'h0BADF00D, 0);
    wait_done(20);

    // Back-to-back load from DONE
    do_start(32'd2);
    chk("b2b_done_low", 64'(ld.done), 64'd0);
    chk("b2b_busy", 64'(ld.busy), 64'd1);
    send_word(32'd0, 32'h01020304, 1);
    send_word(32'd1, 32'hF0E0D0C0, 1);
    wait_done(20);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
